mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit that sits beside the single-cycle ALU in the MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers over multiple cycles, using a start/busy/done handshake. The core stalls on Busy.
- Also performs MTHI/MTLO writes. HI/LO are always readable for MFHI/MFLO.
- The ALU returns its result combinationally; this block is its multi-cycle counterpart, holding results until they are read back.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle request; sampled only when Busy=0.
- Md_Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are no-op.
- Read_Data_1  input  WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO data).
- Read_Data_2  input  WIDTH  rt operand (multiplier or divisor).
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when HI/LO are updated by a mul/div.
- Div_Zero  output  1  pulses with Done when a divide had divisor 0.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, Div_Zero=0, counter=0. Reset mid-operation aborts the operation; no Done is produced.
- Outputs Busy, Done and Div_Zero are decoded from registered state only, with no combinational path from inputs.
- FSM states: IDLE, RUN, FIN.
  - IDLE -> RUN: on Start with Md_Op in 000..011 and divisor nonzero (or any multiply). Operands are latched at this edge.
  - IDLE -> FIN: on Start with DIV/DIVU and Read_Data_2=0; no iterations are run.
  - RUN -> FIN: when counter = WIDTH-1. RUN lasts exactly WIDTH cycles.
  - FIN -> IDLE: unconditionally after one cycle.
- Busy = (state != IDLE). Done = (state == FIN).
- Latency: Start sampled at edge 0 gives Busy high from edge 0 and Done high in the cycle after edge WIDTH (33rd cycle), which is 1 cycle for divide-by-zero. Hi/Lo hold their new values from the edge entering FIN.
- Multiply (shift-add, one bit per cycle):
  - Signed: operate on magnitudes; negate the 2*WIDTH product if the operand signs differ.
  - Result: Hi = product[63:32], Lo = product[31:0].
- Divide (restoring, one quotient bit per cycle, magnitudes for signed):
  - Quotient sign = sign(rs) XOR sign(rt). Remainder sign = sign(rs).
  - Lo = quotient, Hi = remainder.
  - 0x80000000 / -1 (signed): Lo=0x80000000, Hi=0, no exception.
- Divide by zero: Lo=0xFFFFFFFF, Hi=Read_Data_1 unchanged, Div_Zero=1 during the FIN cycle.
- MTHI/MTLO: only while IDLE with Start=1. Writes Hi (or Lo) at that edge; the other register is unchanged. Busy stays 0 and Done stays 0.
- Start while Busy=1: ignored; operands and Md_Op are not re-latched.
- Start with undefined Md_Op (110, 111): no state change and no register write.
- Hi/Lo are never partially updated during RUN. Intermediate product/quotient lives in internal registers and is committed to Hi/Lo at entry to FIN.
- Start in the same cycle Done is high: ignored, since Busy=1. A new op can be accepted in the cycle after Done.

Test Plan:
- Reset then MULT rs=0xFFFFFFFF, rt=0x00000002 -> after 33 cycles Done=1, Hi=0xFFFFFFFF, Lo=0xFFFFFFFE; Busy high for exactly 33 cycles.
- MULTU with the same operands -> Hi=0x00000001, Lo=0xFFFFFFFE. Then MULTU 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU rs=7, rt=2 -> Lo=3, Hi=1. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU rs=0x12345678, rt=0 -> Done and Div_Zero both pulse 1 cycle after Start; Lo=0xFFFFFFFF, Hi=0x12345678.
- Start MULT 3*5, then assert Start with MTLO 0xAAAA at cycle 10 -> the MTLO is ignored; final Hi=0, Lo=15. A following MTHI 0x55 while idle -> Hi=0x55 next edge, Lo=15, no Done.
- Start DIV, pull rst_n low at cycle 12 -> immediately Busy=0, Hi=Lo=0, and no Done after release. A new MULT 2*3 then completes with Lo=6.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative multiply/divide unit beside the MIPS ALU. Executes
//            MULT/MULTU (shift-add) and DIV/DIVU (restoring) one bit per
//            cycle into the architectural HI/LO registers, and performs
//            MTHI/MTLO writes. HI/LO are always readable.
// Ports    : clk         - rising-edge clock
//            rst_n       - asynchronous active-low reset
//            Start       - one-cycle request, sampled only while idle
//            Md_Op       - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                          100 MTHI, 101 MTLO, others no-op
//            Read_Data_1 - rs (multiplicand / dividend / MTHI-MTLO data)
//            Read_Data_2 - rt (multiplier / divisor)
//            Busy        - operation in flight (core stalls)
//            Done        - one-cycle pulse when HI/LO updated by mul/div
//            Div_Zero    - pulses with Done when divisor was zero
//            Hi, Lo      - HI and LO registers
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       Md_Op,
  input  logic [WIDTH-1:0] Read_Data_1,
  input  logic [WIDTH-1:0] Read_Data_2,
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Working registers. For multiply, {acc_hi, acc_lo} is the partial product
  // with the multiplier shifting out of the bottom of acc_lo. For divide,
  // acc_hi is the partial remainder and acc_lo shifts the dividend out of
  // the top while quotient bits enter at the bottom.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_main;  // negate product (mul) or quotient (div)
  logic             neg_rem;   // negate remainder (div only)
  logic             dz;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic             idle_start;
  logic             req_mul;
  logic             req_div;
  logic             req_signed;
  logic             divisor_zero;
  logic [WIDTH-1:0] mag_1;
  logic [WIDTH-1:0] mag_2;

  always_comb begin
    idle_start   = (state == IDLE) && Start;
    req_mul      = (Md_Op == OP_MULT) || (Md_Op == OP_MULTU);
    req_div      = (Md_Op == OP_DIV)  || (Md_Op == OP_DIVU);
    // Signed variants have Md_Op[0] clear.
    req_signed   = !Md_Op[0];
    divisor_zero = (Read_Data_2 == '0);
    // Magnitudes; the most negative value maps onto itself, which is the
    // correct unsigned magnitude.
    mag_1 = (req_signed && Read_Data_1[WIDTH-1]) ? (~Read_Data_1 + 1'b1) : Read_Data_1;
    mag_2 = (req_signed && Read_Data_2[WIDTH-1]) ? (~Read_Data_2 + 1'b1) : Read_Data_2;
  end

  // ---------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right by one.
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Restoring divide: the remainder is always below the divisor, so the
    // trial difference fits in WIDTH+1 bits and its MSB is a clean borrow.
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_hi    = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_lo    = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};

    step_hi = is_div ? div_hi : mul_hi;
    step_lo = is_div ? div_lo : mul_lo;
  end

  // ---------------------------------------------------------------------
  // Final sign correction applied to the last iteration's result, so HI/LO
  // are committed on the same edge that enters FIN.
  // ---------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  always_comb begin
    prod_mag = {mul_hi, mul_lo};
    prod_fix = neg_main ? (~prod_mag + 1'b1) : prod_mag;
    quo_fix  = neg_main ? (~div_lo + 1'b1) : div_lo;
    rem_fix  = neg_rem  ? (~div_hi + 1'b1) : div_hi;
    fin_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    fin_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Start && req_mul) begin
          state_next = RUN;
        end else if (Start && req_div) begin
          // Divide by zero skips the iterations entirely.
          state_next = divisor_zero ? FIN : RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_ITER) begin
          state_next = FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Hi       <= '0;
      Lo       <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          dz  <= 1'b0;
          if (idle_start) begin
            if (req_mul) begin
              acc_hi   <= '0;
              acc_lo   <= mag_2;
              opnd     <= mag_1;
              is_div   <= 1'b0;
              neg_main <= req_signed && (Read_Data_1[WIDTH-1] ^ Read_Data_2[WIDTH-1]);
              neg_rem  <= 1'b0;
            end else if (req_div) begin
              if (divisor_zero) begin
                Hi <= Read_Data_1;
                Lo <= '1;
                dz <= 1'b1;
              end else begin
                acc_hi   <= '0;
                acc_lo   <= mag_1;
                opnd     <= mag_2;
                is_div   <= 1'b1;
                neg_main <= req_signed && (Read_Data_1[WIDTH-1] ^ Read_Data_2[WIDTH-1]);
                neg_rem  <= req_signed && Read_Data_1[WIDTH-1];
              end
            end else if (Md_Op == OP_MTHI) begin
              Hi <= Read_Data_1;
            end else if (Md_Op == OP_MTLO) begin
              Lo <= Read_Data_1;
            end
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            Hi <= fin_hi;
            Lo <= fin_lo;
          end
        end
        FIN: begin
          dz <= 1'b0;
        end
        default: begin
          dz <= 1'b0;
        end
      endcase
    end
  end

  // Status outputs come purely from registered state.
  always_comb begin
    Busy     = (state != IDLE);
    Done     = (state == FIN);
    Div_Zero = (state == FIN) && dz;
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Self-checking bench for mul_div_unit. Directed scenarios plus
//            randomized operations compared against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          Start;
  logic [2:0]    Md_Op;
  logic [W-1:0]  Read_Data_1;
  logic [W-1:0]  Read_Data_2;
  logic          Busy;
  logic          Done;
  logic          Div_Zero;
  logic [W-1:0]  Hi;
  logic [W-1:0]  Lo;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Start       (Start),
    .Md_Op       (Md_Op),
    .Read_Data_1 (Read_Data_1),
    .Read_Data_2 (Read_Data_2),
    .Busy        (Busy),
    .Done        (Done),
    .Div_Zero    (Div_Zero),
    .Hi          (Hi),
    .Lo          (Lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: 64-bit products and SV truncating division.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
    longint      sp, sq, sr;
    logic [63:0] up;
    edz = 1'b0;
    eh  = '0;
    el  = '0;
    case (op)
      3'b000: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = sp;
        eh = up[63:32]; el = up[31:0];
      end
      3'b001: begin
        up = {32'b0, a} * {32'b0, b};
        eh = up[63:32]; el = up[31:0];
      end
      default: begin
        if (b == 0) begin
          eh = a; el = 32'hFFFF_FFFF; edz = 1'b1;
        end else if (op == 3'b010) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          up = sq; el = up[31:0];
          up = sr; eh = up[31:0];
        end else begin
          up = {32'b0, a} / {32'b0, b}; el = up[31:0];
          up = {32'b0, a} % {32'b0, b}; eh = up[31:0];
        end
      end
    endcase
  endtask

  // Present a request for one edge, then scramble the operand buses.
  task automatic pulse(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    Start = 1'b1; Md_Op = op; Read_Data_1 = a; Read_Data_2 = b;
    @(posedge clk);
    #1;
    Start = 1'b0; Md_Op = 3'($urandom_range(0, 7));
    Read_Data_1 = $urandom; Read_Data_2 = $urandom;
  endtask

  // Wait (bounded) for Done; reports edges waited and whether Busy stayed
  // high and Hi/Lo stayed frozen at the given values meanwhile.
  task automatic wait_done(input logic [W-1:0] h0, input logic [W-1:0] l0,
                           output int n, output logic hold_ok);
    n = 0;
    hold_ok = 1'b1;
    while (!Done && n < 100) begin
      if (!Busy || Hi !== h0 || Lo !== l0) hold_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_check(input string tag, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el, h0, l0;
    logic         edz, hold_ok;
    int           n;
    model(op, a, b, eh, el, edz);
    h0 = Hi; l0 = Lo;
    pulse(op, a, b);
    check({tag, ".busy0"}, 64'(Busy), 64'd1);
    wait_done(h0, l0, n, hold_ok);
    check({tag, ".latency"}, 64'(n), edz ? 64'd0 : 64'd32);
    check({tag, ".hold"}, 64'(hold_ok), 64'd1);
    check({tag, ".dz"}, 64'(Div_Zero), 64'(edz));
    check({tag, ".hi"}, 64'(Hi), 64'(eh));
    check({tag, ".lo"}, 64'(Lo), 64'(el));
    @(posedge clk);
    #1;
    check({tag, ".idle"}, {62'b0, Busy, Done}, 64'd0);
  endtask

  initial begin : stim
    logic [2:0]   op;
    logic [W-1:0] a, b;
    int           n;
    logic         hold_ok;
    logic         saw_done;

    Start = 1'b0; Md_Op = 3'b000; Read_Data_1 = '0; Read_Data_2 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.status", {61'b0, Busy, Done, Div_Zero}, 64'd0);
    check("reset.hilo", {Hi, Lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_check("mult_neg", 3'b000, 32'hFFFF_FFFF, 32'h0000_0002);
    run_check("multu", 3'b001, 32'hFFFF_FFFF, 32'h0000_0002);
    run_check("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("div_neg", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    run_check("divu", 3'b011, 32'h0000_0007, 32'h0000_0002);
    run_check("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("mult_minmin", 3'b000, 32'h8000_0000, 32'h8000_0000);

    // Divide by zero, then a request during the FIN cycle must be ignored.
    pulse(3'b011, 32'h1234_5678, 32'h0);
    check("dz.done", {62'b0, Done, Div_Zero}, 64'd3);
    check("dz.hilo", {Hi, Lo}, {32'h1234_5678, 32'hFFFF_FFFF});
    pulse(3'b100, 32'hDEAD_BEEF, 32'h0);
    check("fin_start_ignored", {Hi, 29'b0, Busy, Done, Div_Zero}, {32'h1234_5678, 32'd0});
    pulse(3'b100, 32'hDEAD_BEEF, 32'h0);
    check("mthi_after_fin", 64'(Hi), 64'h0000_0000_DEAD_BEEF);

    // Undefined opcode: no state change, no write.
    pulse(3'b110, 32'h1111_1111, 32'h2222_2222);
    check("undef_op", {Hi, Lo}, {32'hDEAD_BEEF, 32'hFFFF_FFFF});
    check("undef_op.busy", 64'(Busy), 64'd0);

    // MTLO during a multiply is ignored.
    pulse(3'b000, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    pulse(3'b101, 32'h0000_AAAA, 32'h0);
    wait_done(32'hDEAD_BEEF, 32'hFFFF_FFFF, n, hold_ok);
    check("busy_mtlo.done", 64'(Done), 64'd1);
    check("busy_mtlo.hilo", {Hi, Lo}, {32'd0, 32'd15});
    @(posedge clk);
    #1;
    pulse(3'b100, 32'h0000_0055, 32'h0);
    check("mthi.hilo", {Hi, Lo}, {32'h55, 32'd15});
    check("mthi.status", {62'b0, Busy, Done}, 64'd0);

    // Reset mid-divide aborts without a Done.
    pulse(3'b010, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.status", {62'b0, Busy, Done}, 64'd0);
    check("abort.hilo", {Hi, Lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (Done || Busy) saw_done = 1'b1;
    end
    check("abort.no_done", 64'(saw_done), 64'd0);
    run_check("mult_after_rst", 3'b000, 32'd2, 32'd3);

    // Randomized operations against the model.
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        default: ;
      endcase
      run_check($sformatf("rand%0d", i), op, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
